// File: rtl/io_pulse_sequencer_pkg.sv
`default_nettype none
// io_pulse_sequencer_pkg -- register map, CTRL field positions and FSM encoding (rev 1.0)
package io_pulse_sequencer_pkg;

  localparam logic [6:0] PSEQ_BASE_ADDR = 7'd64;

  localparam logic [6:0] PSEQ_OFS_CTRL  = 7'd0;
  localparam logic [6:0] PSEQ_OFS_TABLE = 7'd1;
  localparam logic [6:0] PSEQ_OFS_IDLE  = 7'd2;
  localparam logic [6:0] PSEQ_OFS_DELAY = 7'd3;

  localparam logic [6:0] FR_PSEQ_CTRL  = PSEQ_BASE_ADDR + PSEQ_OFS_CTRL;
  localparam logic [6:0] FR_PSEQ_TABLE = PSEQ_BASE_ADDR + PSEQ_OFS_TABLE;
  localparam logic [6:0] FR_PSEQ_IDLE  = PSEQ_BASE_ADDR + PSEQ_OFS_IDLE;
  localparam logic [6:0] FR_PSEQ_DELAY = PSEQ_BASE_ADDR + PSEQ_OFS_DELAY;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_LAST_LSB    = 4;
  localparam int CTRL_CLR_OVR_BIT = 31;

  typedef logic [1:0] pseq_state_t;
  localparam pseq_state_t ST_IDLE  = 2'd0;
  localparam pseq_state_t ST_DELAY = 2'd1;
  localparam pseq_state_t ST_RUN   = 2'd2;

  // A zero duration still has to show the entry for one cycle.
  function automatic logic [15:0] pseq_min1(input logic [15:0] dur);
    return (dur == 16'd0) ? 16'd1 : dur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_pulse_sequencer_if.sv
`default_nettype none
// io_pulse_sequencer_if -- serial control bus write port (rev 1.0)
interface io_pulse_sequencer_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, output serial_data, output serial_strobe);
  modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface
`default_nettype wire

// File: rtl/io_pulse_sequencer_pseq_table.sv
`default_nettype none
// io_pulse_sequencer_pseq_table -- DEPTH x 32 entry file, one write port, one async read port (rev 1.0)
module io_pulse_sequencer_pseq_table #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_we,
  input  wire logic [IDX_W-1:0] i_waddr,
  input  wire logic [31:0]      i_wdata,
  input  wire logic [IDX_W-1:0] i_raddr,
  output logic      [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/io_pulse_sequencer.sv
`default_nettype none
// io_pulse_sequencer -- trigger-launched (pattern, duration) table player for an I/O bank (rev 1.0)
module io_pulse_sequencer
  import io_pulse_sequencer_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter int         IDX_W     = 3,
  parameter int         CNT_W     = 16,
  parameter logic [6:0] BASE_ADDR = PSEQ_BASE_ADDR
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  io_pulse_sequencer_if.slave   bus,
  input  wire logic             i_trigger,
  output logic      [15:0]      o_pattern,
  output logic                  o_active,
  output logic      [IDX_W-1:0] o_seq_index,
  output logic      [7:0]       o_overrun_count
);

  logic [6:0]       w_ofs;
  logic             w_wr_ctrl, w_wr_table, w_wr_idle, w_wr_delay, w_clr_ovr;
  logic             w_unused_data;

  logic             r_enable;
  logic [IDX_W-1:0] r_last_index;
  logic [IDX_W-1:0] r_wptr;
  logic [15:0]      r_idle_pattern;
  logic [CNT_W-1:0] r_delay;

  pseq_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_seq_index;
  logic [15:0]      r_pattern;
  logic [7:0]       r_overrun;

  logic             w_load;
  logic [IDX_W-1:0] w_load_idx;
  logic [31:0]      w_entry;

  // Offset from the block base; addresses below the base wrap far out of range.
  assign w_ofs         = bus.serial_addr - BASE_ADDR;
  assign w_wr_ctrl     = bus.serial_strobe && (w_ofs == PSEQ_OFS_CTRL);
  assign w_wr_table    = bus.serial_strobe && (w_ofs == PSEQ_OFS_TABLE);
  assign w_wr_idle     = bus.serial_strobe && (w_ofs == PSEQ_OFS_IDLE);
  assign w_wr_delay    = bus.serial_strobe && (w_ofs == PSEQ_OFS_DELAY);
  assign w_clr_ovr     = w_wr_ctrl && bus.serial_data[CTRL_CLR_OVR_BIT];
  assign w_unused_data = ^bus.serial_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enable       <= 1'b0;
      r_last_index   <= '0;
      r_wptr         <= '0;
      r_idle_pattern <= '0;
      r_delay        <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable     <= bus.serial_data[CTRL_ENABLE_BIT];
        r_last_index <= bus.serial_data[CTRL_LAST_LSB +: IDX_W];
      end
      if (w_wr_idle)  r_idle_pattern <= bus.serial_data[15:0];
      if (w_wr_delay) r_delay        <= bus.serial_data[CNT_W-1:0];
      if (w_wr_ctrl)       r_wptr <= '0;
      else if (w_wr_table) r_wptr <= r_wptr + IDX_W'(1);
    end
  end

  io_pulse_sequencer_pseq_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_wr_table),
    .i_waddr (r_wptr),
    .i_wdata (bus.serial_data),
    .i_raddr (w_load_idx),
    .o_rdata (w_entry)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_trigger && r_enable) begin
          if (r_delay == '0) begin
            w_state_nxt = ST_RUN;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (!r_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (!r_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          if (r_seq_index == r_last_index) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_load     = 1'b1;
            w_load_idx = r_seq_index + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_seq_index <= '0;
      r_pattern   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_pattern   <= w_entry[15:0];
        r_cnt       <= CNT_W'(pseq_min1(w_entry[31:16]));
        r_seq_index <= w_load_idx;
      end else if (w_state_nxt == ST_IDLE) begin
        r_pattern   <= r_idle_pattern;
        r_cnt       <= '0;
        r_seq_index <= '0;
      end else if (r_state == ST_IDLE) begin
        r_pattern <= r_idle_pattern;
        r_cnt     <= r_delay;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_state == ST_DELAY) r_pattern <= r_idle_pattern;
      end
    end
  end

  // A clear in the same cycle as a trigger takes priority over the increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= '0;
    end else if (w_clr_ovr) begin
      r_overrun <= '0;
    end else if (i_trigger && (r_state != ST_IDLE) && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  always_comb begin
    o_active        = (r_state != ST_IDLE);
    o_pattern       = r_pattern;
    o_seq_index     = r_seq_index;
    o_overrun_count = r_overrun;
  end

endmodule
`default_nettype wire

// File: tb/tb_io_pulse_sequencer.sv
`default_nettype none
// tb_io_pulse_sequencer -- vector table, directed corner sequences and randomized model comparison (rev 1.0)
module tb_io_pulse_sequencer;
  import io_pulse_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] o_pattern;
  logic        o_active;
  logic [2:0]  o_seq_index;
  logic [7:0]  o_overrun_count;

  io_pulse_sequencer_if ifc ();

  io_pulse_sequencer #(
    .DEPTH     (8),
    .IDX_W     (3),
    .CNT_W     (16),
    .BASE_ADDR (PSEQ_BASE_ADDR)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .bus             (ifc),
    .i_trigger       (trigger),
    .o_pattern       (o_pattern),
    .o_active        (o_active),
    .o_seq_index     (o_seq_index),
    .o_overrun_count (o_overrun_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a triggered sequence is expanded into a queue of per-cycle output slots.
  typedef struct {
    logic [15:0] pat;
    logic        is_idle;
    logic [2:0]  idx;
  } slot_t;

  slot_t       q[$];
  logic        m_en;
  logic [2:0]  m_last, m_wptr;
  logic [15:0] m_idle, m_delay;
  logic [31:0] m_tab [8];
  logic [15:0] e_pat;
  logic        e_act;
  logic [2:0]  e_idx;
  logic [7:0]  e_ovr;

  typedef struct {
    logic        trig;
    logic [15:0] pat;
    logic        act;
    logic [2:0]  idx;
  } vec_t;
  vec_t tv [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 1'b0; m_last = '0; m_wptr = '0; m_idle = '0; m_delay = '0;
    for (int i = 0; i < 8; i++) m_tab[i] = '0;
    e_pat = '0; e_act = 1'b0; e_idx = '0; e_ovr = '0;
  endtask

  task automatic model_edge(input logic trig, input logic wr, input logic [6:0] a, input logic [31:0] d);
    logic  was_act;
    slot_t s;
    int    n;
    was_act = e_act;
    if (!m_en) q.delete();
    if (trig) begin
      if (was_act) begin
        if (e_ovr != 8'hFF) e_ovr = e_ovr + 8'd1;
      end else if (m_en) begin
        for (int i = 0; i < int'(m_delay); i++) q.push_back('{16'h0, 1'b1, 3'd0});
        for (int k = 0; k <= int'(m_last); k++) begin
          n = (m_tab[k][31:16] == 16'd0) ? 1 : int'(m_tab[k][31:16]);
          for (int j = 0; j < n; j++) q.push_back('{m_tab[k][15:0], 1'b0, 3'(k)});
        end
      end
    end
    if (wr && a == FR_PSEQ_CTRL && d[31]) e_ovr = '0;
    if (q.size() > 0) begin
      s     = q.pop_front();
      e_act = 1'b1;
      e_pat = s.is_idle ? m_idle : s.pat;
      e_idx = s.idx;
    end else begin
      e_act = 1'b0;
      e_pat = m_idle;
      e_idx = '0;
    end
    if (wr) begin
      case (a)
        FR_PSEQ_CTRL:  begin m_en = d[0]; m_last = d[CTRL_LAST_LSB +: 3]; m_wptr = '0; end
        FR_PSEQ_TABLE: begin m_tab[m_wptr] = d; m_wptr = m_wptr + 3'd1; end
        FR_PSEQ_IDLE:  m_idle = d[15:0];
        FR_PSEQ_DELAY: m_delay = d[15:0];
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic trig, input logic wr, input logic [6:0] a, input logic [31:0] d);
    trigger           = trig;
    ifc.serial_strobe = wr;
    ifc.serial_addr   = a;
    ifc.serial_data   = d;
    model_edge(trig, wr, a, d);
    @(posedge clk);
    #1;
    trigger           = 1'b0;
    ifc.serial_strobe = 1'b0;
    check("pattern", 32'(o_pattern), 32'(e_pat));
    check("active", 32'(o_active), 32'(e_act));
    check("seq_index", 32'(o_seq_index), 32'(e_idx));
    check("overrun", 32'(o_overrun_count), 32'(e_ovr));
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 7'd0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && e_act; i++) idle(1);
    check("drain_idle", 32'(o_active), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [2:0] rlast;
    ifc.serial_addr = '0; ifc.serial_data = '0; ifc.serial_strobe = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_pattern", 32'(o_pattern), 32'd0);
    check("rst_active", 32'(o_active), 32'd0);
    check("rst_seq_index", 32'(o_seq_index), 32'd0);
    check("rst_overrun", 32'(o_overrun_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic three-entry table, no delay.
    wr_reg(FR_PSEQ_CTRL, 32'h0000_0021);
    wr_reg(FR_PSEQ_TABLE, {16'd4, 16'h0001});
    wr_reg(FR_PSEQ_TABLE, {16'd2, 16'h0003});
    wr_reg(FR_PSEQ_TABLE, {16'd1, 16'h0000});
    wr_reg(FR_PSEQ_IDLE, 32'h0000_8000);
    wr_reg(FR_PSEQ_DELAY, 32'd0);
    tv[0] = '{1'b0, 16'h8000, 1'b0, 3'd0};
    tv[1] = '{1'b1, 16'h0001, 1'b1, 3'd0};
    tv[2] = '{1'b0, 16'h0001, 1'b1, 3'd0};
    tv[3] = '{1'b0, 16'h0001, 1'b1, 3'd0};
    tv[4] = '{1'b0, 16'h0001, 1'b1, 3'd0};
    tv[5] = '{1'b0, 16'h0003, 1'b1, 3'd1};
    tv[6] = '{1'b0, 16'h0003, 1'b1, 3'd1};
    tv[7] = '{1'b0, 16'h0000, 1'b1, 3'd2};
    tv[8] = '{1'b0, 16'h8000, 1'b0, 3'd0};
    tv[9] = '{1'b0, 16'h8000, 1'b0, 3'd0};
    for (int i = 0; i < 10; i++) begin
      cycle(tv[i].trig, 1'b0, 7'd0, 32'd0);
      check("tv_pattern", 32'(o_pattern), 32'(tv[i].pat));
      check("tv_active", 32'(o_active), 32'(tv[i].act));
      check("tv_seq_index", 32'(o_seq_index), 32'(tv[i].idx));
    end

    // Same table with a five-cycle launch delay.
    wr_reg(FR_PSEQ_DELAY, 32'd5);
    idle(1);
    cycle(1'b1, 1'b0, 7'd0, 32'd0);
    check("dly_pattern", 32'(o_pattern), 32'h8000);
    check("dly_active", 32'(o_active), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("dly_pattern", 32'(o_pattern), 32'h8000);
      check("dly_active", 32'(o_active), 32'd1);
    end
    idle(1);
    check("dly_first_entry", 32'(o_pattern), 32'h0001);
    drain();
    wr_reg(FR_PSEQ_DELAY, 32'd0);

    // Overrun counting, saturation and clear-wins-over-trigger.
    wr_reg(FR_PSEQ_CTRL, 32'h0000_0021);
    wr_reg(FR_PSEQ_TABLE, {16'd200, 16'h0011});
    wr_reg(FR_PSEQ_TABLE, {16'd200, 16'h0022});
    wr_reg(FR_PSEQ_TABLE, {16'd200, 16'h0033});
    cycle(1'b1, 1'b0, 7'd0, 32'd0);
    idle(1);
    cycle(1'b1, 1'b0, 7'd0, 32'd0);
    check("ovr_first", 32'(o_overrun_count), 32'd1);
    check("ovr_no_restart", 32'(o_pattern), 32'h0011);
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 7'd0, 32'd0);
    check("ovr_saturate", 32'(o_overrun_count), 32'd255);
    check("ovr_seq_index", 32'(o_seq_index), 32'd1);
    cycle(1'b1, 1'b1, FR_PSEQ_CTRL, 32'h8000_0021);
    check("ovr_clear_wins", 32'(o_overrun_count), 32'd0);
    drain();

    // Zero duration, and the ninth TABLE write wrapping onto entry 0.
    wr_reg(FR_PSEQ_CTRL, 32'h0000_0011);
    for (int i = 0; i < 9; i++) begin
      if (i == 8)      wr_reg(FR_PSEQ_TABLE, {16'd0, 16'h00AA});
      else if (i == 1) wr_reg(FR_PSEQ_TABLE, {16'd0, 16'h0101});
      else             wr_reg(FR_PSEQ_TABLE, {16'd3, 16'(16'h0100 + i)});
    end
    cycle(1'b1, 1'b0, 7'd0, 32'd0);
    check("wrap_entry0", 32'(o_pattern), 32'h00AA);
    idle(1);
    check("dur0_entry1", 32'(o_pattern), 32'h0101);
    check("dur0_index1", 32'(o_seq_index), 32'd1);
    idle(1);
    check("dur0_back_idle", 32'(o_pattern), 32'h8000);
    check("dur0_inactive", 32'(o_active), 32'd0);

    // Randomized tables, delays and trigger traffic against the model.
    for (int b = 0; b < 6; b++) begin
      drain();
      rlast = 3'($urandom_range(0, 7));
      wr_reg(FR_PSEQ_CTRL, {27'd0, rlast, 4'b0001} & 32'h0000_007F);
      for (int i = 0; i < 8; i++)
        wr_reg(FR_PSEQ_TABLE, {16'($urandom_range(0, 4)), 16'($urandom)});
      wr_reg(FR_PSEQ_IDLE, {16'd0, 16'($urandom)});
      wr_reg(FR_PSEQ_DELAY, 32'($urandom_range(0, 4)));
      idle(1);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 40) == 0)
          cycle($urandom_range(0, 1) == 1, 1'b1, FR_PSEQ_CTRL, 32'h8000_0001 | (32'(rlast) << 4));
        else
          cycle($urandom_range(0, 5) == 0, 1'b0, 7'd0, 32'd0);
      end
    end
    drain();

    // Abort by clearing enable mid-sequence, then restart.
    wr_reg(FR_PSEQ_IDLE, 32'h0000_8000);
    wr_reg(FR_PSEQ_DELAY, 32'd0);
    wr_reg(FR_PSEQ_CTRL, 32'h0000_0021);
    wr_reg(FR_PSEQ_TABLE, {16'd3, 16'h0001});
    wr_reg(FR_PSEQ_TABLE, {16'd5, 16'h0002});
    wr_reg(FR_PSEQ_TABLE, {16'd3, 16'h0003});
    idle(1);
    cycle(1'b1, 1'b0, 7'd0, 32'd0);
    idle(3);
    check("abort_at_index1", 32'(o_seq_index), 32'd1);
    wr_reg(FR_PSEQ_CTRL, 32'h0000_0020);
    idle(1);
    check("abort_pattern", 32'(o_pattern), 32'h8000);
    check("abort_seq_index", 32'(o_seq_index), 32'd0);
    check("abort_active", 32'(o_active), 32'd0);
    wr_reg(FR_PSEQ_CTRL, 32'h0000_0021);
    cycle(1'b1, 1'b0, 7'd0, 32'd0);
    check("restart_pattern", 32'(o_pattern), 32'h0001);
    check("restart_index", 32'(o_seq_index), 32'd0);
    idle(1);

    // Asynchronous reset in the middle of a running entry.
    #3;
    rst_n = 1'b0;
    #2;
    check("arst_pattern", 32'(o_pattern), 32'd0);
    check("arst_active", 32'(o_active), 32'd0);
    check("arst_seq_index", 32'(o_seq_index), 32'd0);
    check("arst_overrun", 32'(o_overrun_count), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    idle(4);
    check("post_rst_pattern", 32'(o_pattern), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
